// File: rtl/mult_seq_controller.sv
// Sequencing FSM for the shift-and-add signed multiplier datapath.
// Runs LOAD, {CHECK, [ADD], SHIFT}*, CHECK, DONE and stops early once the multiplier register is zero.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for start, ready=1
//  LOAD  | load operands and sign, clear product, zero iteration count
//  CHECK | look at zflag / iteration limit / multiplier lsb
//  ADD   | accumulate multiplicand into product
//  SHIFT | shift multiplicand left and multiplier right, count iteration
//  DONE  | one-cycle done pulse, product and sign valid
module mult_seq_controller #(
    parameter int MAX_ITER = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           zflag,
    input  logic                           lsb_multiplier,
    output logic                           load,
    output logic                           psel,
    output logic                           reg_en,
    output logic                           shift_en,
    output logic                           busy,
    output logic                           ready,
    output logic                           done,
    output logic [$clog2(MAX_ITER+1)-1:0]  iter_cnt
);

    localparam int CW = $clog2(MAX_ITER + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  iter_q, iter_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // zflag outranks the iteration limit, which outranks lsb_multiplier
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                iter_d  = '0;
                state_d = CHECK;
            end
            CHECK: begin
                if (zflag || (iter_q == CW'(MAX_ITER))) state_d = DONE;
                else if (lsb_multiplier)                state_d = ADD;
                else                                    state_d = SHIFT;
            end
            ADD: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (iter_q != CW'(MAX_ITER)) iter_d = iter_q + CW'(1);
                state_d = CHECK;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore decode: controls depend on the registered state only
    always_comb begin
        load     = 1'b0;
        psel     = 1'b0;
        reg_en   = 1'b0;
        shift_en = 1'b0;
        done     = 1'b0;
        ready    = 1'b0;
        busy     = 1'b1;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            LOAD: begin
                load   = 1'b1;
                reg_en = 1'b1;
            end
            ADD: begin
                reg_en = 1'b1;
                psel   = 1'b1;
            end
            SHIFT: begin
                shift_en = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign iter_cnt = iter_q;

endmodule
